bus_select_encoder: RTL and testbench
=====================================

// Module: bus_select_encoder
// PURPOSE
//  Parametrised, registered source-select encoder for the CPU datapath bus mux.
//  Converts N_SRC per-source "drive bus" strobes into a binary select index.
//  Adds valid flag, multi-driver conflict detection, a saturating conflict counter and select lock.
//  Sits between the control unit's *out strobes and the bus multiplexer select input.
// PARAMETERS
//  N_SRC   24                   number of bus sources (R0..R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, C)
//  SEL_W   $clog2(N_SRC)        select index width (5 at default)
//  CNT_W   8                    conflict counter width
// PORTS
//  clk           in   1        rising-edge clock
//  clr           in   1        synchronous active-high reset
//  src_out       in   N_SRC    per-source drive strobes, bit i = source i
//  sel_lock      in   1        1 = hold sel/sel_valid at current values
//  sel           out  SEL_W    registered select index
//  sel_valid     out  1        registered: a source was granted this cycle
//  conflict      out  1        registered: >1 strobe asserted in the sampled cycle
//  conflict_cnt  out  CNT_W    saturating count of conflict cycles
// BEHAVIOUR
//  - One clock domain; single synchronous active-high reset; all state updates on rising clk.
//  - clr=1 at an edge: sel=0, sel_valid=0, conflict=0, conflict_cnt=0, rr_ptr=0; clr overrides all inputs.
//  - Latency: src_out sampled at edge k, so sel/sel_valid/conflict reflect it after edge k (1 cycle).
//  - Grant (fixed priority): lowest asserted index wins (bit 0 highest priority).
//  - src_out==0: sel holds its previous value, sel_valid=0, conflict=0.
//  - Any bit set: sel=granted index, sel_valid=1.
//  - conflict=1 iff popcount(src_out)>=2; conflict_cnt increments that cycle and saturates at 2^CNT_W-1.
//  - Counter is not wrapped; once saturated it stays saturated until clr.
//  - sel_lock=1: sel and sel_valid hold; conflict and conflict_cnt still update from src_out.
//  - sel_lock=1 and clr=1 together: clr wins.
//  - Bits of src_out at index >= N_SRC do not exist.
//  - sel never exceeds N_SRC-1.
//  - No FSM beyond the registers above; no combinational input-to-output path.
// CONFIGURATION
//  BUS_SEL_RR_EN defined:
//  - Arbitration is round-robin. Search starts at index rr_ptr and wraps N_SRC-1 -> 0.
//  - First asserted bit found wins.
//  - On each unlocked grant, rr_ptr <= granted+1, wrapping at N_SRC to 0.
//  - rr_ptr holds when no grant or when sel_lock=1.
//  - A single asserted bit is always granted regardless of rr_ptr.
//  BUS_SEL_RR_EN undefined:
//  - Fixed lowest-index priority as above; no rr_ptr register exists.
//  Conflict logic is identical in both builds.
// TESTING
//  1 reset: clr=1 with src_out=24'hFFFFFF, 2 edges
//    -> sel=0, sel_valid=0, conflict=0, conflict_cnt=0.
//  2 walk: one-hot src_out bit i, i=0..23, one per cycle
//    -> next cycle sel=i, sel_valid=1, conflict=0.
//    -> e.g. bit 20 (PC) gives sel=5'd20.
//  3 conflict: src_out=(1<<3)|(1<<17)
//    -> sel=3 (fixed build), conflict=1, conflict_cnt +1.
//  4 idle hold and saturation: src_out=0 after sel=7
//    -> sel=7, sel_valid=0.
//    -> 300 conflict cycles with CNT_W=8 give conflict_cnt=255, not wrapped.
//  5 lock: grant sel=9, then sel_lock=1 with src_out=bit 2 for 3 cycles
//    -> sel=9 throughout.
//    -> release lock -> sel=2 one cycle later.
//  6 BUS_SEL_RR_EN: src_out=(1<<1)|(1<<5) held 4 cycles from reset
//    -> sel sequence 1,5,1,5.
//    -> wrap check: grant 23, then bits 0|23 -> sel=0.

Source files
------------

// File: rtl/bus_select_encoder.sv
// Registered bus source-select encoder with conflict detection and select lock.
// Optional round-robin arbitration when BUS_SEL_RR_EN is defined.
module bus_select_encoder #(
    parameter int N_SRC = 24,
    parameter int SEL_W = $clog2(N_SRC),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] src_out,
    input  logic             sel_lock,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic             any_req;
    logic             multi_req;
    logic [SEL_W-1:0] grant;

    assign any_req   = |src_out;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req = |(src_out & (src_out - N_SRC'(1)));

`ifdef BUS_SEL_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_next;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= N_SRC) j = j - N_SRC;
            if (!found && src_out[j]) begin
                grant = SEL_W'(j);
                found = 1'b1;
            end
        end
    end

    assign rr_next = (grant == SEL_W'(N_SRC - 1)) ? '0 : grant + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            rr_ptr <= '0;
        end else if (any_req && !sel_lock) begin
            rr_ptr <= rr_next;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) grant = SEL_W'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            sel          <= '0;
            sel_valid    <= 1'b0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (!sel_lock) begin
                sel_valid <= any_req;
                if (any_req) sel <= grant;
            end
            conflict <= multi_req;
            if (multi_req && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_select_encoder.sv
// Self-checking bench for bus_select_encoder (default fixed-priority build).
module tb_bus_select_encoder;

    localparam int N = 24;

    logic          clk;
    logic          clr;
    logic [N-1:0]  src_out;
    logic          sel_lock;
    logic [4:0]    sel;
    logic          sel_valid;
    logic          conflict;
    logic [7:0]    conflict_cnt;

    int tests = 0;
    int fails = 0;

    int m_sel = 0;
    int m_valid = 0;
    int m_conf = 0;
    int m_cnt = 0;

    bus_select_encoder dut (
        .clk(clk),
        .clr(clr),
        .src_out(src_out),
        .sel_lock(sel_lock),
        .sel(sel),
        .sel_valid(sel_valid),
        .conflict(conflict),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic        l;
        logic [23:0] s;
        int          e_sel;
        int          e_valid;
        int          e_conf;
        int          e_cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [23:0] s);
        logic [23:0] iso;
        iso = s & (~s + 24'd1);
        return $clog2(iso);
    endfunction

    task automatic model(input logic c, input logic l, input logic [23:0] s);
        if (c) begin
            m_sel = 0; m_valid = 0; m_conf = 0; m_cnt = 0;
        end else begin
            if (!l) begin
                m_valid = (s != 0) ? 1 : 0;
                if (s != 0) m_sel = lowest(s);
            end
            m_conf = ($countones(s) >= 2) ? 1 : 0;
            if (m_conf == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic cycle(input logic c, input logic l, input logic [23:0] s,
                         input bit check_all);
        clr = c; sel_lock = l; src_out = s;
        @(posedge clk);
        model(c, l, s);
        #1;
        if (check_all) begin
            chk("sel", int'(sel), m_sel);
            chk("sel_valid", int'(sel_valid), m_valid);
            chk("conflict", int'(conflict), m_conf);
            chk("conflict_cnt", int'(conflict_cnt), m_cnt);
        end
    endtask

    vec_t vt[16];

    initial begin
        clr = 1'b1; sel_lock = 1'b0; src_out = '0;

        vt[0]  = '{1, 0, 24'hFFFFFF, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 24'hFFFFFF, 0, 0, 0, 0};
        vt[2]  = '{0, 0, 24'h100000, 20, 1, 0, 0};
        vt[3]  = '{0, 0, 24'h020008, 3, 1, 1, 1};
        vt[4]  = '{0, 0, 24'h000000, 3, 0, 0, 1};
        vt[5]  = '{0, 0, 24'h000080, 7, 1, 0, 1};
        vt[6]  = '{0, 0, 24'h000000, 7, 0, 0, 1};
        vt[7]  = '{0, 0, 24'h000200, 9, 1, 0, 1};
        vt[8]  = '{0, 1, 24'h000004, 9, 1, 0, 1};
        vt[9]  = '{0, 1, 24'h000004, 9, 1, 0, 1};
        vt[10] = '{0, 1, 24'h000004, 9, 1, 0, 1};
        vt[11] = '{0, 0, 24'h000004, 2, 1, 0, 1};
        vt[12] = '{1, 1, 24'h000020, 0, 0, 0, 0};
        vt[13] = '{0, 0, 24'h800000, 23, 1, 0, 0};
        vt[14] = '{0, 1, 24'h000000, 23, 1, 0, 0};
        vt[15] = '{0, 1, 24'h000003, 23, 1, 1, 1};

        foreach (vt[k]) begin
            cycle(vt[k].c, vt[k].l, vt[k].s, 1'b1);
            chk($sformatf("vec%0d_sel", k), int'(sel), vt[k].e_sel);
            chk($sformatf("vec%0d_valid", k), int'(sel_valid), vt[k].e_valid);
            chk($sformatf("vec%0d_conf", k), int'(conflict), vt[k].e_conf);
            chk($sformatf("vec%0d_cnt", k), int'(conflict_cnt), vt[k].e_cnt);
        end

        for (int i = 0; i < N; i++) begin
            logic [23:0] oh;
            oh = 24'd1 << i;
            cycle(1'b0, 1'b0, oh, 1'b1);
            chk($sformatf("walk%0d_sel", i), int'(sel), i);
            chk($sformatf("walk%0d_conf", i), int'(conflict), 0);
        end

        cycle(1'b1, 1'b0, 24'h0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            logic [23:0] s;
            s = (24'($urandom()) | 24'h000001) | (24'd1 << $urandom_range(1, 23));
            cycle(1'b0, 1'b0, s, 1'b0);
        end
        chk("sat_cnt", int'(conflict_cnt), 255);
        chk("sat_model", int'(conflict_cnt), m_cnt);
        cycle(1'b0, 1'b0, 24'h000C00, 1'b1);
        chk("sat_hold", int'(conflict_cnt), 255);

        for (int i = 0; i < 600; i++) begin
            logic [23:0] s;
            logic        c;
            logic        l;
            case ($urandom_range(0, 3))
                0: s = '0;
                1: s = 24'd1 << $urandom_range(0, 23);
                2: s = 24'($urandom()) & 24'($urandom());
                default: s = 24'($urandom());
            endcase
            c = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 3) == 0);
            cycle(c, l, s, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
